// File: rtl/scr1_tb_imem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tb_imem_responder_pkg
//  Description : Shared instruction-memory interface encodings (response
//                codes, command codes) and request classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package scr1_tb_imem_responder_pkg;

    // Response code driven on imem_resp
    typedef enum logic [1:0] {
        IMEM_RESP_IDLE  = 2'b00,
        IMEM_RESP_OKAY  = 2'b01,
        IMEM_RESP_ERROR = 2'b10
    } imem_resp_e;

    // Command code sampled on imem_cmd
    typedef enum logic {
        IMEM_CMD_RD = 1'b0,
        IMEM_CMD_WR = 1'b1
    } imem_cmd_e;

    // A request fails when it is a write (instruction memory is read-only),
    // is not word aligned, or addresses a word beyond the backing array.
    function automatic logic imem_req_is_err(
        input logic        cmd,
        input logic [31:0] addr,
        input int unsigned mem_words
    );
        return (cmd == IMEM_CMD_WR)
            || (addr[1:0] != 2'b00)
            || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage : scr1_tb_imem_responder_pkg
`default_nettype wire

// File: rtl/scr1_tb_imem_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tb_imem_req_fifo
//  Description : Small synchronous FIFO holding pending memory requests.
//                Pointers wrap modulo DEPTH; an occupancy counter separates
//                full from empty so any DEPTH (not only powers of two) works.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_tb_imem_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   store_q [DEPTH];
    logic [c_PTR_W-1:0] wptr_q;
    logic [c_PTR_W-1:0] rptr_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o    = (cnt_q == c_CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign rdata_o   = store_q[rptr_q];

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            store_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop leaves occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_do_push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (w_do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (w_do_push && !w_do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule : scr1_tb_imem_req_fifo
`default_nettype wire

// File: rtl/scr1_tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tb_imem_responder
//  Description : Bench-side instruction memory model. Accepts requests into a
//                small in-order queue, retires the head after a fixed latency
//                and returns OKAY+data or ERROR for one cycle. A preload port
//                writes the backing array.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_tb_imem_responder
    import scr1_tb_imem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic        imem_cmd,
    input  logic [31:0] imem_addr,
    output logic        imem_req_ack,
    output logic [31:0] imem_rdata,
    output logic [1:0]  imem_resp,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int       c_MEM_AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    // Only the in-range index bits are queued: out-of-range requests are
    // already flagged as errors and never index the array.
    localparam int       c_ENTRY_W = c_MEM_AW + 1;
    localparam logic [3:0] c_LAT    = 4'(LATENCY);
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    logic [31:0]          mem_q [MEM_WORDS];
    logic [3:0]           lat_cnt_q;
    logic [3:0]           lat_cnt_d;
    imem_resp_e           resp_q;
    imem_resp_e           resp_d;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_ENTRY_W-1:0] w_new_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;
    logic [c_ENTRY_W-1:0] w_ret_entry;
    logic                 w_accept;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_retire;

    assign w_new_entry  = {imem_addr[c_MEM_AW+1:2],
                           imem_req_is_err(imem_cmd, imem_addr, MEM_WORDS)};
    assign imem_req_ack = imem_req && !w_fifo_full && !rst;
    assign w_accept     = imem_req_ack;
    // With a single-cycle latency a request arriving at an empty queue is
    // already due on its acceptance edge, so it skips the queue entirely.
    assign w_bypass     = w_accept && w_fifo_empty && (LATENCY == 1);
    assign w_push       = w_accept && !w_bypass;
    assign w_pop        = !w_fifo_empty && (lat_cnt_q == 4'd1);
    assign w_retire     = w_pop || w_bypass;
    assign w_ret_entry  = w_bypass ? w_new_entry : w_head_entry;

    scr1_tb_imem_req_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_new_entry),
        .rdata_o (w_head_entry),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Head latency countdown: an entry accepted into an empty queue counts
    // its acceptance cycle, a follower starts a full LATENCY after the pop
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (w_pop) begin
            lat_cnt_d = c_LAT;
        end else if (w_push && w_fifo_empty) begin
            lat_cnt_d = c_LAT_M1;
        end else if (!w_fifo_empty && (lat_cnt_q != 4'd0)) begin
            lat_cnt_d = lat_cnt_q - 4'd1;
        end
    end

    // Response formation; array is read on the retire edge (old data wins a
    // same-edge preload)
    always_comb begin
        resp_d  = IMEM_RESP_IDLE;
        rdata_d = '0;
        if (w_retire) begin
            if (w_ret_entry[0]) begin
                resp_d = IMEM_RESP_ERROR;
            end else begin
                resp_d  = IMEM_RESP_OKAY;
                rdata_d = mem_q[w_ret_entry[c_ENTRY_W-1:1]];
            end
        end
    end

    // Counter and one-cycle response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt_q <= '0;
            resp_q    <= IMEM_RESP_IDLE;
            rdata_q   <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Preload port; array survives reset, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (load_en && (load_addr < 32'(MEM_WORDS))) begin
            mem_q[load_addr[c_MEM_AW-1:0]] <= load_data;
        end
    end

    assign imem_resp  = resp_q;
    assign imem_rdata = rdata_q;

endmodule : scr1_tb_imem_responder
`default_nettype wire

// File: tb/tb_scr1_tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scr1_tb_imem_responder
//  Description : Self-checking bench. Four responders with different
//                latency/depth share one stimulus stream; a timing-formula
//                reference model predicts ack, response code and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_tb_imem_responder;

    localparam int MW    = 64;
    localparam int N_DUT = 4;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        case (i)
            0:       return 2;
            1:       return 2;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int p;      // edge at which this request retires
        int idx;
        bit err;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic        ack_w   [N_DUT];
    logic [31:0] rdata_w [N_DUT];
    logic [1:0]  resp_w  [N_DUT];

    logic [1:0]  exp_resp  [N_DUT];
    logic [31:0] exp_rdata [N_DUT];
    ent_t        mq [N_DUT][$];
    logic [31:0] m_mem [MW];
    int          cyc;
    int          n_ack [N_DUT];
    int          n_rsp [N_DUT];
    int          n_tests;
    int          n_fail;
    bit          chk_en;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 1 : 4;
        localparam int D = (gi == 0) ? 2 : (gi == 1) ? 2 : (gi == 2) ? 4 : 3;
        scr1_tb_imem_responder #(
            .MEM_WORDS   (MW),
            .LATENCY     (L),
            .QUEUE_DEPTH (D)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .imem_req     (req),
            .imem_cmd     (cmd),
            .imem_addr    (addr),
            .imem_req_ack (ack_w[gi]),
            .imem_rdata   (rdata_w[gi]),
            .imem_resp    (resp_w[gi]),
            .load_en      (load_en),
            .load_addr    (load_addr),
            .load_data    (load_data)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: each accepted request retires at
    // max(accept_edge + L - 1, previous_retire + L); occupancy counts accepted
    // requests whose retire edge has not yet passed.
    always @(posedge clk) begin : p_model
        ent_t e;
        for (int i = 0; i < N_DUT; i++) begin
            if (rst) begin
                mq[i].delete();
                exp_resp[i]  = 2'b00;
                exp_rdata[i] = 32'h0;
            end else begin
                if (req && (mq[i].size() < dep_of(i))) begin
                    e.idx = int'(addr[31:2]);
                    e.err = cmd || (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(MW));
                    e.p   = cyc + lat_of(i) - 1;
                    if ((mq[i].size() > 0) && (mq[i][$].p + lat_of(i) > e.p))
                        e.p = mq[i][$].p + lat_of(i);
                    mq[i].push_back(e);
                end
                exp_resp[i]  = 2'b00;
                exp_rdata[i] = 32'h0;
                if ((mq[i].size() > 0) && (mq[i][0].p == cyc)) begin
                    e = mq[i].pop_front();
                    if (e.err) begin
                        exp_resp[i] = 2'b10;
                    end else begin
                        exp_resp[i]  = 2'b01;
                        exp_rdata[i] = m_mem[e.idx];
                    end
                end
            end
        end
        if (load_en && (load_addr < 32'(MW)))
            m_mem[load_addr] = load_data;
        cyc++;
    end

    // Per-cycle comparison of every responder against the model
    always @(negedge clk) begin : p_check
        logic exp_ack;
        if (chk_en) begin
            for (int i = 0; i < N_DUT; i++) begin
                exp_ack = req && !rst && (mq[i].size() < dep_of(i));
                check($sformatf("ack[%0d]", i),   32'(ack_w[i]),  32'(exp_ack));
                check($sformatf("resp[%0d]", i),  32'(resp_w[i]), 32'(exp_resp[i]));
                check($sformatf("rdata[%0d]", i), rdata_w[i],     exp_rdata[i]);
                if (rst) begin
                    n_ack[i] = 0;
                    n_rsp[i] = 0;
                end else begin
                    if (ack_w[i])           n_ack[i]++;
                    if (resp_w[i] != 2'b00) n_rsp[i]++;
                end
            end
        end
    end

    initial begin
        int w;
        n_tests = 0; n_fail = 0; cyc = 0; chk_en = 0;
        for (int i = 0; i < N_DUT; i++) begin
            n_ack[i] = 0; n_rsp[i] = 0;
        end
        rst = 1'b1; req = 1'b0; cmd = 1'b0; addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        step();
        chk_en = 1;
        step();
        step();
        rst = 1'b0;

        // Preload the whole array, then try an out-of-range load
        for (int k = 0; k < MW; k++) begin
            load_en   = 1'b1;
            load_addr = 32'(k);
            load_data = (k == 4) ? 32'h0000_F033 : $urandom;
            step();
        end
        load_addr = 32'(MW);
        load_data = 32'hDEAD_BEEF;
        step();
        load_en = 1'b0;
        step();

        // Single read of word 4, explicit timing on the LATENCY=2 responder
        req = 1'b1; cmd = 1'b0; addr = 32'h10;
        step();
        req = 1'b0;
        @(negedge clk);
        check("single_rd_early", 32'(resp_w[0]), 32'h0);
        @(negedge clk);
        check("single_rd_resp",  32'(resp_w[0]), 32'h1);
        check("single_rd_data",  rdata_w[0],     32'h0000_F033);
        @(negedge clk);
        check("single_rd_after", 32'(resp_w[0]), 32'h0);
        step();
        repeat (6) step();

        // Misaligned read, write, out-of-range read; then read of word 0
        req = 1'b1; cmd = 1'b0; addr = 32'h12;
        step();
        cmd = 1'b1; addr = 32'h0;
        step();
        cmd = 1'b0; addr = 32'(MW * 4);
        step();
        addr = 32'h0;
        step();
        req = 1'b0;
        repeat (20) step();

        // Request held high for six cycles
        req = 1'b1; cmd = 1'b0;
        for (int k = 0; k < 6; k++) begin
            addr = 32'($urandom_range(0, MW - 1) * 4);
            step();
        end
        req = 1'b0;
        repeat (25) step();

        // Reset with requests in flight, then read word 4 again
        req = 1'b1; addr = 32'h10;
        step();
        addr = 32'h14;
        step();
        req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req = 1'b1; addr = 32'h10;
        step();
        req = 1'b0;
        repeat (10) step();

        // Preload landing between acceptance and response
        req = 1'b1; addr = 32'h20;
        step();
        req = 1'b0;
        load_en = 1'b1; load_addr = 32'd8; load_data = 32'hAAAA_5555;
        step();
        load_en = 1'b0;
        repeat (10) step();

        // Continuous requests to consecutive words
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr = 32'(k * 4);
            step();
        end
        req = 1'b0;
        repeat (10) step();

        // Randomised traffic with interleaved preloads and rare resets
        for (int k = 0; k < 400; k++) begin
            req = ($urandom_range(0, 9) < 7);
            cmd = ($urandom_range(0, 9) == 0);
            w   = $urandom_range(0, MW + 5);
            addr = 32'(w * 4) + (($urandom_range(0, 11) == 0) ? 32'd2 : 32'd0);
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = 32'($urandom_range(0, MW + 2));
            load_data = $urandom;
            rst = (k < 350) && ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; req = 1'b0; load_en = 1'b0;
        repeat (30) step();

        // Every accepted request since the last reset got exactly one response
        for (int i = 0; i < N_DUT; i++)
            check($sformatf("count[%0d]", i), 32'(n_rsp[i]), 32'(n_ack[i]));

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scr1_tb_imem_responder
`default_nettype wire
